// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer slice.
//   state_t   : sequencer FSM states
//   cause_t   : encoding of the latched reset cause (rst_cause)
//   cnt_width : counter width for a terminal count, never below 1 bit
package rst_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABILIZE,
    REL_SYS,
    REL_PERIPH,
    RUN
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR  = 2'd0;
  localparam cause_t CAUSE_LOCK = 2'd1;
  localparam cause_t CAUSE_BTN  = 2'd2;
  localparam cause_t CAUSE_WDT  = 2'd3;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Status and control bundle between the reset sequencer and its environment.
//   pll_locked   : synchronized PLL lock flag (to sequencer)
//   btn_n_in     : raw push-button reset, active-low, bouncy (to sequencer)
//   wdt_kick     : watchdog kick pulse (to sequencer)
//   sys_rst_n    : core reset, active-low (from sequencer)
//   periph_rst_n : peripheral reset, active-low (from sequencer)
//   ready        : system running (from sequencer)
//   rst_cause    : cause of the last reset sequence (from sequencer)
// master = sequencer side, slave = environment side.
interface reset_sequencer_if;
  import rst_pkg::*;

  logic   pll_locked;
  logic   btn_n_in;
  logic   wdt_kick;
  logic   sys_rst_n;
  logic   periph_rst_n;
  logic   ready;
  cause_t rst_cause;

  modport master (
    input  pll_locked, btn_n_in, wdt_kick,
    output sys_rst_n, periph_rst_n, ready, rst_cause
  );

  modport slave (
    output pll_locked, btn_n_in, wdt_kick,
    input  sys_rst_n, periph_rst_n, ready, rst_cause
  );

endinterface

// File: rtl/reset_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, and a
// one-cycle request pulse on each filtered high-to-low transition.
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   btn_n   : raw asynchronous button, active-low
//   btn_req : one-cycle pulse when the filtered button becomes pressed
module btn_debounce
  import rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_req
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             filt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      filt    <= 1'b1;
      cnt     <= '0;
      btn_req <= 1'b0;
    end else begin
      // p0 -> p1: metastability settling
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      // p1 -> filtered: level must persist for the full count
      btn_req <= 1'b0;
      if (sync_p1 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        filt    <= sync_p1;
        cnt     <= '0;
        btn_req <= ~sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer running on the PLL output clock. Holds the core and
// peripheral resets until the PLL has been locked for STABLE_CYCLES, releases
// the core reset, then the peripheral reset PERIPH_DELAY cycles later. Lock
// loss, a debounced button press or (optionally) a watchdog timeout restart
// the sequence and latch the cause.
//   clock_in : PLL output clock, all logic on posedge
//   rst_in   : synchronous active-low reset
//   io       : reset_sequencer_if.master (lock, button, kick in; resets,
//              ready, rst_cause out)
// Optional build macro RESET_SEQUENCER_WDT_EN adds the watchdog; without it
// wdt_kick is ignored and rst_cause never reads 3.
module reset_sequencer
  import rst_pkg::*;
#(
  parameter int STABLE_CYCLES   = 1024,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int PERIPH_DELAY    = 256,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic                clock_in,
  input  logic                rst_in,
  reset_sequencer_if.master   io
);

  localparam int               STAB_W   = cnt_width(STABLE_CYCLES);
  localparam int               DLY_W    = cnt_width(PERIPH_DELAY);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [DLY_W-1:0]  DLY_MAX  = DLY_W'(PERIPH_DELAY - 1);

  state_t            state;
  state_t            next_state;
  logic [STAB_W-1:0] stab_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  logic              btn_req;
  logic              wdt_expire;
  logic              released;
  logic              fault;
  cause_t            fault_cause;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clock_in),
    .rst_n   (rst_in),
    .btn_n   (io.btn_n_in),
    .btn_req (btn_req)
  );

`ifdef RESET_SEQUENCER_WDT_EN
  localparam int              WDT_W   = cnt_width(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // Counts only while staying in RUN, so it reads 0 on RUN entry and
  // returns to 0 on the same edge a fault leaves RUN.
  always_ff @(posedge clock_in) begin
    if (!rst_in) begin
      wdt_cnt <= '0;
    end else if (state != RUN || next_state != RUN || io.wdt_kick) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_MAX) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  assign wdt_expire = (state == RUN) && (wdt_cnt == WDT_MAX);
`else
  logic unused_wdt;
  assign unused_wdt = io.wdt_kick | (WDT_CYCLES == 0);
  assign wdt_expire = 1'b0;
`endif

  // Faults only matter once the core reset has been released; before that
  // the sequence is still holding everything in reset anyway.
  always_comb begin
    released    = (state == REL_SYS) || (state == REL_PERIPH) || (state == RUN);
    fault       = released && (!io.pll_locked || btn_req || wdt_expire);
    fault_cause = !io.pll_locked ? CAUSE_LOCK :
                  btn_req        ? CAUSE_BTN  : CAUSE_WDT;
    next_state  = state;
    if (fault) begin
      next_state = HOLD;
    end else begin
      case (state)
        HOLD:       next_state = WAIT_LOCK;
        WAIT_LOCK:  if (!btn_req && io.pll_locked) next_state = STABILIZE;
        STABILIZE: begin
          if (btn_req || !io.pll_locked) next_state = WAIT_LOCK;
          else if (stab_cnt == STAB_MAX) next_state = REL_SYS;
        end
        REL_SYS:    if (dly_cnt == DLY_MAX) next_state = REL_PERIPH;
        REL_PERIPH: next_state = RUN;
        RUN:        next_state = RUN;
        default:    next_state = HOLD;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the
  // state register: resets fall together and release strictly in order.
  always_ff @(posedge clock_in) begin
    if (!rst_in) begin
      state           <= HOLD;
      stab_cnt        <= '0;
      dly_cnt         <= '0;
      io.sys_rst_n    <= 1'b0;
      io.periph_rst_n <= 1'b0;
      io.ready        <= 1'b0;
      io.rst_cause    <= CAUSE_POR;
    end else begin
      state <= next_state;

      if (state == STABILIZE && next_state == STABILIZE && stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;
      else if (!(state == STABILIZE && next_state == STABILIZE))
        stab_cnt <= '0;

      if (state == REL_SYS && next_state == REL_SYS && dly_cnt != DLY_MAX)
        dly_cnt <= dly_cnt + 1'b1;
      else if (!(state == REL_SYS && next_state == REL_SYS))
        dly_cnt <= '0;

      io.sys_rst_n    <= (next_state == REL_SYS) || (next_state == REL_PERIPH) ||
                         (next_state == RUN);
      io.periph_rst_n <= (next_state == REL_PERIPH) || (next_state == RUN);
      io.ready        <= (next_state == RUN);

      if (fault)
        io.rst_cause <= fault_cause;
      else if (btn_req && !released)
        io.rst_cause <= CAUSE_BTN;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STABLE_CYCLES=8, DEBOUNCE_CYCLES=4,
// PERIPH_DELAY=4, WDT_CYCLES=16. Inputs change 1 time unit after each rising
// edge and outputs are sampled at the same point.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst_in;
  bit   auto_kick;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   drops;

  always #5 clk = ~clk;

  reset_sequencer_if io ();

  reset_sequencer #(
    .STABLE_CYCLES   (8),
    .DEBOUNCE_CYCLES (4),
    .PERIPH_DELAY    (4),
    .WDT_CYCLES      (16)
  ) dut (
    .clock_in (clk),
    .rst_in   (rst_in),
    .io       (io)
  );

  task automatic tick();
    if (auto_kick) io.wdt_kick = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return io.sys_rst_n;
      1:       return io.periph_rst_n;
      2:       return io.ready;
      default: return ~io.sys_rst_n;
    endcase
  endfunction

  // Ticks until the probed condition is 1; n == limit means it never came.
  task automatic wait_for(input int which, input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (probe(which) !== 1'b1 && cnt < limit);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in        = 1'b0;
    io.pll_locked = 1'b0;
    io.btn_n_in   = 1'b1;
    io.wdt_kick   = 1'b0;
    auto_kick     = 1'b1;

    // Power-up: reset for 5 cycles, lock from cycle 2
    tick(); tick();
    io.pll_locked = 1'b1;
    tick(); tick(); tick();
    chk("por_sys_rst_n", io.sys_rst_n, 0);
    chk("por_periph_rst_n", io.periph_rst_n, 0);
    chk("por_ready", io.ready, 0);
    chk("por_cause", io.rst_cause, 0);
    rst_in = 1'b1;
    // HOLD, WAIT_LOCK, then 8 cycles of STABILIZE
    wait_for(0, 100, n);
    chk("por_sys_latency", n, 10);
    chk("por_periph_still_low", io.periph_rst_n, 0);
    wait_for(1, 100, n);
    chk("por_periph_delay", n, 4);
    chk("por_sys_held_high", io.sys_rst_n, 1);
    wait_for(2, 100, n);
    chk("por_ready_latency", n, 1);
    chk("por_run_cause", io.rst_cause, 0);

    // Lock loss in RUN
    io.pll_locked = 1'b0;
    tick();
    chk("lock_sys_low", io.sys_rst_n, 0);
    chk("lock_periph_low", io.periph_rst_n, 0);
    chk("lock_ready_low", io.ready, 0);
    chk("lock_cause", io.rst_cause, 1);
    tick(); tick(); tick();
    chk("lock_wait_sys_low", io.sys_rst_n, 0);
    io.pll_locked = 1'b1;
    wait_for(0, 100, n);
    chk("lock_relock_latency", n, 9);
    chk("lock_order_periph_low", io.periph_rst_n, 0);
    wait_for(1, 100, n);
    chk("lock_periph_delay", n, 4);
    wait_for(2, 100, n);
    chk("lock_ready_latency", n, 1);
    chk("lock_cause_kept", io.rst_cause, 1);

    // rst_in while running clears everything including the cause
    rst_in = 1'b0;
    tick(); tick();
    chk("rstin_sys_low", io.sys_rst_n, 0);
    chk("rstin_ready_low", io.ready, 0);
    chk("rstin_cause_cleared", io.rst_cause, 0);

    // Lock glitch at stable count 5 restarts the full interval
    rst_in = 1'b1;
    tick();                     // HOLD -> WAIT_LOCK
    tick();                     // -> STABILIZE, count 0
    repeat (5) tick();          // count 5
    io.pll_locked = 1'b0;
    tick();
    chk("glitch_sys_low", io.sys_rst_n, 0);
    io.pll_locked = 1'b1;
    wait_for(0, 100, n);
    chk("glitch_relock_latency", n, 9);
    wait_for(1, 100, n);
    chk("glitch_periph_delay", n, 4);
    wait_for(2, 100, n);
    chk("glitch_ready_latency", n, 1);

    // Button bounce: 2 low / 1 high never survives the filter
    for (int r = 0; r < 3; r++) begin
      io.btn_n_in = 1'b0; tick(); tick();
      io.btn_n_in = 1'b1; tick();
      chk("bounce_no_reset", io.ready, 1);
    end
    for (int i = 0; i < 6; i++) begin
      io.btn_n_in = 1'b0;
      tick();
    end
    chk("btn_before_fault", io.sys_rst_n, 1);
    io.btn_n_in = 1'b1;
    tick();
    chk("btn_sys_low", io.sys_rst_n, 0);
    chk("btn_periph_low", io.periph_rst_n, 0);
    chk("btn_cause", io.rst_cause, 2);
    wait_for(0, 100, n);
    chk("btn_relock_latency", n, 10);
    wait_for(2, 100, n);
    chk("btn_ready_latency", n, 5);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (io.ready !== 1'b1) drops++;
    end
    chk("btn_single_sequence", drops, 0);
    chk("btn_cause_kept", io.rst_cause, 2);

    // Lock loss coinciding with btn_req: lock wins
    for (int i = 0; i < 6; i++) begin
      io.btn_n_in = 1'b0;
      tick();
    end
    io.btn_n_in   = 1'b1;
    io.pll_locked = 1'b0;
    tick();
    chk("both_sys_low", io.sys_rst_n, 0);
    chk("both_cause", io.rst_cause, 1);
    io.pll_locked = 1'b1;
    wait_for(0, 100, n);
    chk("both_relock_latency", n, 10);
    wait_for(2, 100, n);
    chk("both_ready_latency", n, 5);
    chk("both_cause_kept", io.rst_cause, 1);

`ifdef RESET_SEQUENCER_WDT_EN
    // Kicks every 10 cycles keep the system running
    auto_kick = 1'b0;
    drops = 0;
    for (int i = 0; i < 200; i++) begin
      io.wdt_kick = (i % 10 == 0);
      tick();
      if (io.ready !== 1'b1) drops++;
    end
    chk("wdt_kicked_no_reset", drops, 0);
    // Last kick, then silence: expiry after 16 cycles
    io.wdt_kick = 1'b1;
    tick();
    io.wdt_kick = 1'b0;
    wait_for(3, 100, n);
    chk("wdt_expiry_latency", n, 16);
    chk("wdt_periph_low", io.periph_rst_n, 0);
    chk("wdt_cause", io.rst_cause, 3);
`else
    // Without the watchdog, silence never resets anything
    auto_kick   = 1'b0;
    io.wdt_kick = 1'b0;
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (io.ready !== 1'b1) drops++;
    end
    chk("nowdt_no_reset", drops, 0);
    chk("nowdt_cause", io.rst_cause, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
